// File: rtl/mem_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared encodings for the memory/IO bus slave: FSM state
//               codes, address region codes, the watchdog read pattern and
//               the address decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_IO_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_ACK      = 2'd3;

    // Address region codes
    localparam logic [1:0] c_REGION_MEM   = 2'd0;
    localparam logic [1:0] c_REGION_IO    = 2'd1;
    localparam logic [1:0] c_REGION_UNMAP = 2'd2;

    // Read data returned when the IO watchdog expires
    localparam logic [31:0] c_TIMEOUT_DATA = 32'hFFFF_FFFF;

    // IO window wins over memory; memory is every address whose bits above
    // the word-address field are all zero; everything else is unmapped.
    function automatic logic [1:0] decode_region(input logic [31:0] addr,
                                                 input int          mem_aw,
                                                 input logic [15:0] io_hi);
        if (addr[31:16] == io_hi)
            return c_REGION_IO;
        else if ((addr >> (mem_aw + 2)) == 32'd0)
            return c_REGION_MEM;
        else
            return c_REGION_UNMAP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bus_wait_cnt
// Description : Loadable down-counter with a zero flag. Holds at zero once
//               reached; load has priority over decrement.
// Revision    : 1.0  initial release
// ============================================================================
module bus_wait_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load on request, otherwise count down while enabled and saturate at zero
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (en && (r_count != '0))
            r_count <= r_count - WIDTH'(1);
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Bus slave / address decoder behind the MMU master port.
//               Routes each request to main memory (fixed wait states), the
//               IO port (ready handshake) or the unmapped error response,
//               and returns a single-cycle ack with read data.
//               Optional macro MEM_BUS_TIMEOUT_EN adds an IO watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int          MEM_AW     = 16,
    parameter int          MEM_WS     = 3,
    parameter logic [15:0] IO_BASE_HI = 16'hFFFF,
    parameter logic [31:0] UNMAP_DATA = 32'hDEAD_BEEF,
    parameter int          IO_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_cyc,
    input  logic              s_we,
    input  logic [3:0]        s_strb,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_wdata,
    output logic              s_ack,
    output logic [31:0]       s_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              io_sel,
    output logic              io_we,
    output logic [15:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_rdy,
    output logic              bus_err
);

    import mem_bus_pkg::*;

    // One counter width serves both the wait-state and watchdog counters
    localparam int c_MEM_W = $clog2(MEM_WS + 1);
    localparam int c_IO_W  = $clog2(IO_TIMEOUT + 1);
    localparam int c_CNT_W = (c_MEM_W > c_IO_W) ? c_MEM_W : c_IO_W;
    localparam logic [c_CNT_W-1:0] c_MEM_LOAD = c_CNT_W'(MEM_WS - 1);

    logic [1:0]        r_state;
    logic              r_we;
    logic [3:0]        r_strb;
    logic [31:0]       r_wdata;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [15:0]       r_io_addr;
    logic [31:0]       r_rdata;
    logic              r_bus_err;

    logic [1:0]        w_region;
    logic              w_accept;
    logic              w_in_mem;
    logic              w_in_io;
    logic              w_mem_zero;

    assign w_region = decode_region(s_addr, MEM_AW, IO_BASE_HI);
    assign w_accept = (r_state == c_ST_IDLE) && s_cyc;
    assign w_in_mem = (r_state == c_ST_MEM_WAIT);
    assign w_in_io  = (r_state == c_ST_IO_WAIT);

    bus_wait_cnt #(.WIDTH(c_CNT_W)) u_mem_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept && (w_region == c_REGION_MEM)),
        .load_val (c_MEM_LOAD),
        .en       (w_in_mem),
        .zero     (w_mem_zero)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_IO_LOAD = c_CNT_W'(IO_TIMEOUT - 1);
    logic w_io_zero;

    bus_wait_cnt #(.WIDTH(c_CNT_W)) u_io_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept && (w_region == c_REGION_IO)),
        .load_val (c_IO_LOAD),
        .en       (w_in_io),
        .zero     (w_io_zero)
    );
`endif

    // Request capture, routing and completion sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_we       <= 1'b0;
            r_strb     <= 4'b0;
            r_wdata    <= 32'd0;
            r_mem_addr <= '0;
            r_io_addr  <= 16'd0;
            r_rdata    <= 32'd0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (s_cyc) begin
                        r_we       <= s_we;
                        r_strb     <= s_strb;
                        r_wdata    <= s_wdata;
                        r_mem_addr <= s_addr[MEM_AW+1:2];
                        r_io_addr  <= s_addr[15:0];
                        case (w_region)
                            c_REGION_MEM: r_state <= c_ST_MEM_WAIT;
                            c_REGION_IO:  r_state <= c_ST_IO_WAIT;
                            default: begin
                                // Unmapped: writes are dropped, error is sticky
                                r_rdata   <= UNMAP_DATA;
                                r_bus_err <= 1'b1;
                                r_state   <= c_ST_ACK;
                            end
                        endcase
                    end
                end
                c_ST_MEM_WAIT: begin
                    if (w_mem_zero) begin
                        r_rdata <= r_we ? 32'd0 : mem_rdata;
                        r_state <= c_ST_ACK;
                    end
                end
                c_ST_IO_WAIT: begin
                    // A ready arriving on the watchdog's last cycle still completes normally
                    if (io_rdy) begin
                        r_rdata <= r_we ? 32'd0 : io_rdata;
                        r_state <= c_ST_ACK;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (w_io_zero) begin
                        r_rdata   <= c_TIMEOUT_DATA;
                        r_bus_err <= 1'b1;
                        r_state   <= c_ST_ACK;
                    end
`endif
                end
                c_ST_ACK: r_state <= c_ST_IDLE;
                default:  r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state so they are zero outside their phase
    assign s_ack     = (r_state == c_ST_ACK);
    assign s_rdata   = s_ack ? r_rdata : 32'd0;
    assign mem_ce    = w_in_mem;
    assign mem_we    = w_in_mem & r_we;
    assign mem_be    = w_in_mem ? r_strb : 4'b0;
    assign mem_addr  = w_in_mem ? r_mem_addr : '0;
    assign mem_wdata = w_in_mem ? r_wdata : 32'd0;
    assign io_sel    = w_in_io;
    assign io_we     = w_in_io & r_we;
    assign io_addr   = w_in_io ? r_io_addr : 16'd0;
    assign io_wdata  = w_in_io ? r_wdata : 32'd0;
    assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Self-checking bench for mem_bus_ctrl. A behavioural memory
//               and IO responder drive the DUT; a region/byte-merge reference
//               model predicts read data, latency, side activity and the
//               sticky error flag. Watchdog case runs with MEM_BUS_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int MEM_AW     = 16;
    localparam int MEM_WS     = 3;
    localparam int IO_TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              s_cyc;
    logic              s_we;
    logic [3:0]        s_strb;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic              s_ack;
    logic [31:0]       s_rdata;
    logic              mem_ce;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              io_sel;
    logic              io_we;
    logic [15:0]       io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;
    logic              io_rdy;
    logic              bus_err;

    mem_bus_ctrl #(
        .MEM_AW     (MEM_AW),
        .MEM_WS     (MEM_WS),
        .IO_BASE_HI (16'hFFFF),
        .UNMAP_DATA (32'hDEAD_BEEF),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_cyc     (s_cyc),
        .s_we      (s_we),
        .s_strb    (s_strb),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_ack     (s_ack),
        .s_rdata   (s_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_rdy    (io_rdy),
        .bus_err   (bus_err)
    );

    // Behavioural memory device: async read, byte-enabled write, bench preload port
    bit [31:0]         dev_mem [0:(1<<MEM_AW)-1];
    logic              pre_we;
    logic [MEM_AW-1:0] pre_addr;
    logic [31:0]       pre_data;

    assign mem_rdata = dev_mem[mem_addr];

    always @(posedge clk) begin
        if (pre_we)
            dev_mem[pre_addr] <= pre_data;
        else if (mem_ce && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) dev_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    logic [137:0] all_outs;
    assign all_outs = {s_ack, s_rdata, mem_ce, mem_we, mem_be, mem_addr, mem_wdata,
                       io_sel, io_we, io_addr, io_wdata, bus_err};

    int          tests = 0;
    int          fails = 0;
    bit          ref_err;
    logic [31:0] ref_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: region by address arithmetic, byte merge for writes
    function automatic void model(input logic we, input logic [3:0] strb,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input int io_wait, input logic [31:0] io_data,
                                  output logic [31:0] e_rd, output int e_lat,
                                  output int e_mem, output int e_io);
        longint unsigned a;
        int              w;
        logic [31:0]     old_v;
        logic [31:0]     new_v;
        a = addr;
        e_mem = 0;
        e_io  = 0;
        if (a / 65536 == 65535) begin
            if (io_wait == 0) begin
                e_rd    = 32'hFFFF_FFFF;
                e_lat   = IO_TIMEOUT + 1;
                e_io    = IO_TIMEOUT;
                ref_err = 1'b1;
            end else begin
                e_rd  = we ? 32'd0 : io_data;
                e_lat = io_wait + 1;
                e_io  = io_wait;
            end
        end else if (a < (longint'(1) << (MEM_AW + 2))) begin
            w     = int'(a / 4);
            old_v = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
            if (we) begin
                new_v = old_v;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) new_v[8*b +: 8] = wd[8*b +: 8];
                ref_mem[w] = new_v;
                e_rd = 32'd0;
            end else begin
                e_rd = old_v;
            end
            e_lat = MEM_WS + 1;
            e_mem = MEM_WS;
        end else begin
            e_rd    = 32'hDEAD_BEEF;
            e_lat   = 1;
            ref_err = 1'b1;
        end
    endfunction

    task automatic preload(input int w, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = MEM_AW'(w);
        pre_data = d;
        ref_mem[w] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Master + IO responder for one transaction; called and returns at a negedge
    task automatic xfer(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] wd, input int io_wait, input logic [31:0] io_data,
                        input bit drop, input bit early, input bit keep,
                        output logic [31:0] rd, output int lat, output int n_mem,
                        output int n_io, output bit side_ok);
        bit got;
        s_cyc = 1'b1; s_we = we; s_strb = strb; s_addr = addr; s_wdata = wd;
        io_rdata = io_data;
        io_rdy   = early;
        rd = 'x; lat = 0; n_mem = 0; n_io = 0; side_ok = 1'b1; got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            lat++;
            io_rdy = 1'b0;
            if (drop) s_cyc = 1'b0;
            if (s_ack === 1'b1) begin
                rd  = s_rdata;
                got = 1'b1;
            end else begin
                if (mem_ce === 1'b1) begin
                    n_mem++;
                    if (mem_addr !== addr[MEM_AW+1:2] || mem_we !== we || mem_be !== strb ||
                        (we && mem_wdata !== wd)) side_ok = 1'b0;
                end
                if (io_sel === 1'b1) begin
                    n_io++;
                    if (io_addr !== addr[15:0] || io_we !== we || (we && io_wdata !== wd))
                        side_ok = 1'b0;
                    if (n_io == io_wait) io_rdy = 1'b1;
                end
            end
        end
        if (!keep) begin
            s_cyc = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic op(input string tag, input logic we, input logic [3:0] strb,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int io_wait, input logic [31:0] io_data,
                      input bit drop, input bit early, input bit keep, input bit b2b);
        logic [31:0] e_rd;
        logic [31:0] rd;
        int          e_lat, e_mem, e_io, lat, n_mem, n_io;
        bit          side_ok;
        model(we, strb, addr, wd, io_wait, io_data, e_rd, e_lat, e_mem, e_io);
        if (b2b) e_lat++;
        xfer(we, strb, addr, wd, io_wait, io_data, drop, early, keep, rd, lat, n_mem, n_io, side_ok);
        check({tag, "_rdata"}, rd, e_rd);
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_sides"}, 32'(n_mem * 256 + n_io + (side_ok ? 0 : 65536)),
              32'(e_mem * 256 + e_io));
        check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, ref_err});
        if (!keep) check({tag, "_single_ack"}, {31'd0, s_ack}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running, required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          acks;
        logic [31:0] a;
        int          kind;
        rst = 1'b1; s_cyc = 1'b0; s_we = 1'b0; s_strb = 4'h0; s_addr = 32'd0; s_wdata = 32'd0;
        io_rdy = 1'b0; io_rdata = 32'd0; pre_we = 1'b0; pre_addr = '0; pre_data = 32'd0;
        ref_err = 1'b0;
        repeat (2) @(negedge clk);
        preload(4, 32'h1234_5678);
        preload(8, 32'h1111_2222);
        for (int i = 16; i < 24; i++) preload(i, $urandom);
        check("reset_outputs", 32'(|all_outs), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(|all_outs), 32'd0);

        // Directed memory read/write, partial strobe, re-read
        op("mem_rd4", 1'b0, 4'hF, 32'h0000_0010, 32'd0, 0, 32'd0, 0, 0, 0, 0);
        op("mem_wr8", 1'b1, 4'b0011, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'd0, 0, 0, 0, 0);
        op("mem_rd8", 1'b0, 4'hF, 32'h0000_0020, 32'd0, 0, 32'd0, 0, 0, 0, 0);

        // 8-beat burst with cyc held high, address advanced on each ack
        for (int i = 0; i < 8; i++)
            op($sformatf("burst%0d", i), 1'b0, 4'hF, 32'h0000_0040 + 32'(4 * i), 32'd0,
               0, 32'd0, 0, 0, (i < 7), (i > 0));

        // cyc dropped mid-transaction still completes and commits
        op("drop_wr", 1'b1, 4'hF, 32'h0000_0024, 32'hA5A5_5A5A, 0, 32'd0, 1, 0, 0, 0);
        op("drop_rd", 1'b0, 4'hF, 32'h0000_0024, 32'd0, 0, 32'd0, 0, 0, 0, 0);

        // IO read, then IO write with a stray ready presented while idle
        op("io_rd", 1'b0, 4'hF, 32'hFFFF_0040, 32'd0, 7, 32'h0000_00AB, 0, 0, 0, 0);
        op("io_wr_stray_rdy", 1'b1, 4'hF, 32'hFFFF_0100, 32'h0BAD_F00D, 3, 32'h7777_7777, 0, 1, 0, 0);

        // Top memory word, then unmapped and first-unmapped boundary
        op("mem_top_wr", 1'b1, 4'hF, 32'h0003_FFFC, 32'h0F0F_0F0F, 0, 32'd0, 0, 0, 0, 0);
        op("mem_top_rd", 1'b0, 4'hF, 32'h0003_FFFC, 32'd0, 0, 32'd0, 0, 0, 0, 0);
        op("unmap_rd", 1'b0, 4'hF, 32'h8000_0000, 32'd0, 0, 32'd0, 0, 0, 0, 0);
        op("unmap_edge_wr", 1'b1, 4'hF, 32'h0004_0000, 32'h1357_9BDF, 0, 32'd0, 0, 0, 0, 0);

        // Randomized mix across all regions
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1)
                a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            else if (kind == 2)
                a = {16'hFFFF, 16'($urandom)};
            else
                a = {16'($urandom_range(16'h0004, 16'hFFFE)), 16'($urandom)};
            op($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom), a, $urandom,
               int'($urandom_range(1, 6)), $urandom, 0, 0, 0, 0);
        end

        // Reset during memory wait: no ack, outputs cleared, sticky error cleared
        s_cyc = 1'b1; s_we = 1'b0; s_strb = 4'hF; s_addr = 32'h0000_0010;
        @(negedge clk);
        s_cyc = 1'b0;
        @(negedge clk);
        check("rst_pre_mem_ce", {31'd0, mem_ce}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 32'(|all_outs), 32'd0);
        rst = 1'b0;
        ref_err = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_ack === 1'b1) acks++;
        end
        check("rst_mid_no_ack", 32'(acks), 32'd0);
        op("post_rst_rd", 1'b0, 4'hF, 32'h0000_0010, 32'd0, 0, 32'd0, 0, 0, 0, 0);

`ifdef MEM_BUS_TIMEOUT_EN
        op("io_timeout", 1'b0, 4'hF, 32'hFFFF_0008, 32'd0, 0, 32'd0, 0, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Bus slave and address decoder directly downstream of the CPU MMU master port. Consumes one cyc/we/strb/addr/data request at a time and returns a single-cycle ack with read data.
- Routes each request to main memory (fixed wait states) or the IO device port (ready handshake).
- Unmapped addresses complete with a fixed error pattern.
- Supports back-to-back requests with cyc held high, as used by MMU line fills and evictions.

Parameters:
- MEM_AW, 16: memory word-address width; memory size is 2^MEM_AW words.
- MEM_WS, 3: memory wait cycles per access; minimum 1.
- IO_BASE_HI, 16'hFFFF: addr[31:16] value that selects the IO region.
- UNMAP_DATA, 32'hDEAD_BEEF: read data returned for unmapped addresses.
- IO_TIMEOUT, 64: watchdog limit in cycles; used only with MEM_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_cyc  in  1  request valid, from MMU m_cyc
- s_we  in  1  1 = write
- s_strb  in  4  byte enables
- s_addr  in  32  byte address
- s_wdata  in  32  write data, from MMU m_data_o
- s_ack  out  1  one-cycle completion pulse
- s_rdata  out  32  read data, valid while s_ack=1
- mem_ce  out  1  memory select
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  MEM_AW  word address, s_addr[MEM_AW+1:2]
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- io_sel  out  1  IO request
- io_we  out  1  IO write
- io_addr  out  16  s_addr[15:0]
- io_wdata  out  32  IO write data
- io_rdata  in  32  IO read data
- io_rdy  in  1  IO completion, one cycle
- bus_err  out  1  sticky error flag

Behaviour:
- Only clk and rst are used. rst is synchronous and active-high. On reset, all outputs are 0, state is IDLE, and any in-flight transaction is dropped with no ack.
- States: IDLE, MEM_WAIT, IO_WAIT, ACK.
- IDLE with s_cyc=1:
  - Latch addr, we, strb and wdata into request registers.
  - Decode: addr[31:16]==IO_BASE_HI goes to IO. addr[31:MEM_AW+2]==0 goes to MEM. Anything else is unmapped.
  - MEM: load wait counter with MEM_WS-1, go to MEM_WAIT.
  - IO: go to IO_WAIT.
  - Unmapped: load read register with UNMAP_DATA (writes are dropped), set bus_err, go to ACK.
- MEM_WAIT:
  - mem_ce=1; mem_we=latched we; mem_be, mem_addr and mem_wdata driven from the latched request.
  - Counter decrements each cycle.
  - At count 0: sample mem_rdata into the read register (writes load 0), go to ACK.
  - Memory commits writes on that same edge.
- IO_WAIT:
  - io_sel=1, with io_we, io_addr and io_wdata driven from the latched request.
  - On io_rdy=1: sample io_rdata (writes load 0), go to ACK.
  - Without the optional feature, IO_WAIT waits indefinitely.
- ACK:
  - s_ack=1 and s_rdata = read register; s_rdata is 0 in all other states.
  - Next state is always IDLE. s_cyc is not sampled in ACK, because the master advances its address on the ack edge.
- Latency from s_cyc rise to s_ack:
  - Memory: MEM_WS+1 cycles.
  - Unmapped: 1 cycle.
  - IO: (cycles until io_rdy)+1.
- Back-to-back: with s_cyc held high, a new request is accepted in the IDLE cycle after each ACK.
- Throughput: one memory access per MEM_WS+2 cycles.
- s_cyc dropping mid-transaction: the transaction still completes and s_ack still pulses. The memory/IO side effect is not cancelled.
- io_rdy outside IO_WAIT is ignored.
- bus_err is cleared only by rst.
- Request inputs are ignored outside IDLE.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs during IO_WAIT.
  - After IO_TIMEOUT cycles without io_rdy, go to ACK with read register = 32'hFFFF_FFFF and set bus_err.
  - io_rdy in the same cycle the timeout hits wins: normal completion.
- Undefined: no counter; IO_WAIT waits indefinitely.

Decomposition:
- Package mem_bus_pkg holds:
  - State encodings: IDLE=2'd0, MEM_WAIT=2'd1, IO_WAIT=2'd2, ACK=2'd3.
  - Region codes: MEM, IO, UNMAP.
  - The 32'hFFFF_FFFF timeout data constant.
- One sub-module, bus_wait_cnt: a loadable down-counter with a zero flag. It is instantiated for memory wait states and, under the macro, for the IO watchdog.

Test Plan:
- Read 0x0000_0010, MEM_WS=3, memory word 4 = 32'h1234_5678 -> s_ack exactly 4 cycles after s_cyc, s_rdata=32'h1234_5678, mem_addr=4 for 3 cycles.
- Write 0x0000_0020, data 32'hCAFE_F00D, strb 4'b0011 -> mem_we=1 and mem_be=4'b0011 for 3 cycles; a later read of word 8 returns the low half updated; single ack.
- 8-beat burst, s_cyc held high, addr +4 on each ack -> 8 acks spaced 5 cycles apart, correct data each beat, no skipped or duplicated address.
- Read 0xFFFF_0040, io_rdy after 7 cycles with 32'h0000_00AB -> io_addr=16'h0040, s_ack the next cycle, s_rdata=32'h0000_00AB.
- Read 0x8000_0000 -> s_ack after 1 cycle, s_rdata=32'hDEAD_BEEF, bus_err=1 until rst.
- rst asserted during MEM_WAIT -> no ack, all outputs 0 the next cycle. With MEM_BUS_TIMEOUT_EN and io_rdy never asserted -> ack after 65 cycles with 32'hFFFF_FFFF, bus_err=1.
